// File: rtl/dbus_demux4_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dbus_demux4_pkg : shared types and constants for the data-bus router
// Revision: 1.0
// ---------------------------------------------------------------------------
package dbus_demux4_pkg;

  localparam int SEL_W = 2;
  localparam int NTGT  = 4;
  localparam int CTR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic [NTGT-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    sel_onehot = NTGT'(1) << sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dbus_timeout_ctr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dbus_timeout_ctr : cycle counter that flags the last allowed wait cycle
// Revision: 1.0
// ---------------------------------------------------------------------------
module dbus_timeout_ctr
  import dbus_demux4_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CTR_W-1:0] limit,
  output logic             expired
);

  logic [CTR_W-1:0] count_q, count_d;

  // clear has priority so a REQ->WAIT move restarts the count at zero
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = en && (count_q == (limit - CTR_W'(1)));

endmodule
`default_nettype wire

// File: rtl/dbus_demux4.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dbus_demux4 : one-initiator to four-target load/store router with timeout
// Revision: 1.0
// ---------------------------------------------------------------------------
module dbus_demux4
  import dbus_demux4_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int SEL_LSB = 28,
  parameter int TIMEOUT = 255
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               m_valid,
  output logic               m_ready,
  input  logic               m_we,
  input  logic [AW-1:0]      m_addr,
  input  logic [DW-1:0]      m_wdata,
  output logic               m_rvalid,
  output logic [DW-1:0]      m_rdata,
  output logic               m_err,
  output logic [NTGT-1:0]    s_valid,
  input  logic [NTGT-1:0]    s_ready,
  output logic               s_we,
  output logic [AW-1:0]      s_addr,
  output logic [DW-1:0]      s_wdata,
  input  logic [NTGT-1:0]    s_rvalid,
  input  logic [NTGT*DW-1:0] s_rdata
);

  state_e           state_q, state_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             ctr_clr, ctr_en, ctr_expired;
  logic             tgt_ready, tgt_rvalid;
  logic [DW-1:0]    tgt_rdata;

  always_comb begin
    tgt_rdata = '0;
    for (int i = 0; i < NTGT; i++) begin
      if (sel_q == SEL_W'(i)) begin
        tgt_rdata = s_rdata[i*DW +: DW];
      end
    end
  end

  assign tgt_ready  = s_ready[sel_q];
  assign tgt_rvalid = s_rvalid[sel_q];

  dbus_timeout_ctr u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .limit   (CTR_W'(TIMEOUT)),
    .expired (ctr_expired)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ctr_clr = 1'b0;
    ctr_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (m_valid && m_ready) begin
          we_d    = m_we;
          addr_d  = m_addr;
          wdata_d = m_wdata;
          sel_d   = m_addr[SEL_LSB +: SEL_W];
          ctr_clr = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        ctr_en = 1'b1;
        // a handshake on the timeout cycle still completes normally
        if (tgt_ready) begin
          if (we_q) begin
            rdata_d = '0;
            err_d   = 1'b0;
            state_d = ST_DONE;
          end else if (tgt_rvalid) begin
            rdata_d = tgt_rdata;
            err_d   = 1'b0;
            state_d = ST_DONE;
          end else begin
            ctr_clr = 1'b1;
            state_d = ST_WAIT;
          end
        end else if (ctr_expired) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_WAIT: begin
        ctr_en = 1'b1;
        if (tgt_rvalid) begin
          rdata_d = tgt_rdata;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (ctr_expired) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign m_ready  = (state_q == ST_IDLE) && rst_n;
  assign m_rvalid = (state_q == ST_DONE);
  assign m_rdata  = rdata_q;
  assign m_err    = err_q;
  assign s_valid  = (state_q == ST_REQ) ? sel_onehot(sel_q) : '0;
  assign s_we     = we_q;
  assign s_addr   = addr_q;
  assign s_wdata  = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dbus_demux4.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dbus_demux4 : directed cases plus a randomized cycle-accurate timeline
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_dbus_demux4;

  localparam int DW      = 32;
  localparam int AW      = 32;
  localparam int SEL_LSB = 28;
  localparam int TO      = 4;
  localparam int NC      = 6000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            m_valid, m_ready, m_we;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic            m_rvalid, m_err;
  logic [DW-1:0]   m_rdata;
  logic [3:0]      s_valid, s_ready, s_rvalid;
  logic            s_we;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [4*DW-1:0] s_rdata;

  always #5 clk = ~clk;

  dbus_demux4 #(.DW(DW), .AW(AW), .SEL_LSB(SEL_LSB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_valid(m_valid), .m_ready(m_ready), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
    .s_valid(s_valid), .s_ready(s_ready), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata)
  );

  int n_total = 0;
  int n_bad   = 0;

  // per-cycle stimulus and expected-output timeline for the random phase
  bit              drv_mv [NC];
  bit              drv_we [NC];
  logic [AW-1:0]   drv_addr [NC];
  logic [DW-1:0]   drv_wdata [NC];
  logic [3:0]      drv_sr [NC];
  logic [3:0]      drv_srv [NC];
  logic [4*DW-1:0] drv_srd [NC];
  bit              exp_rdy [NC];
  logic [3:0]      exp_sv [NC];
  bit              exp_rv [NC];
  logic [DW-1:0]   exp_cd [NC];
  bit              exp_ce [NC];
  logic [AW-1:0]   exp_sa [NC];
  bit              exp_swe [NC];
  logic [DW-1:0]   exp_swd [NC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Completion cycle for a request accepted in cycle a. r: REQ cycles before the
  // target's ready (>= TO means never); v: cycles from ready to rvalid (> TO means never).
  function automatic int done_cycle(input int a, input bit we, input int r, input int v,
                                    output bit err);
    int h;
    err = 1'b0;
    if (r >= TO) begin
      err = 1'b1;
      return a + 1 + TO;
    end
    h = a + 1 + r;
    if (we || v == 0) return h + 1;
    if (v <= TO) return h + v + 1;
    err = 1'b1;
    return h + 1 + TO;
  endfunction

  task automatic plan();
    int idle, a, c, r, v, h, sel, nreq;
    bit we, err;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd, rd;
    for (int i = 0; i < NC; i++) begin
      drv_mv[i]    = 1'b0;
      drv_we[i]    = 1'($urandom_range(0, 1));
      drv_addr[i]  = $urandom;
      drv_wdata[i] = $urandom;
      drv_sr[i]    = 4'($urandom);
      drv_srv[i]   = 4'($urandom);
      drv_srd[i]   = {$urandom, $urandom, $urandom, $urandom};
      exp_rdy[i]   = 1'b1;
      exp_sv[i]    = 4'b0;
      exp_rv[i]    = 1'b0;
      exp_cd[i]    = '0;
      exp_ce[i]    = 1'b0;
      exp_sa[i]    = '0;
      exp_swe[i]   = 1'b0;
      exp_swd[i]   = '0;
    end
    idle = 0;
    while (idle < NC - 40) begin
      a    = idle + int'($urandom_range(0, 2));
      we   = 1'($urandom_range(0, 1));
      sel  = int'($urandom_range(0, 3));
      addr = $urandom;
      addr[SEL_LSB +: 2] = 2'(sel);
      wd   = $urandom;
      rd   = $urandom;
      r    = ($urandom_range(0, 4) == 0) ? TO + int'($urandom_range(0, 1))
                                         : int'($urandom_range(0, TO - 1));
      v    = int'($urandom_range(0, TO + 1));
      c    = done_cycle(a, we, r, v, err);
      drv_mv[a] = 1'b1; drv_we[a] = we; drv_addr[a] = addr; drv_wdata[a] = wd;
      if (a == idle && a > 0 && $urandom_range(0, 1) == 1) begin
        drv_mv[a-1] = 1'b1; drv_we[a-1] = we; drv_addr[a-1] = addr; drv_wdata[a-1] = wd;
      end
      for (int i = a + 1; i <= c; i++) begin
        exp_rdy[i] = 1'b0;
        drv_mv[i]  = 1'($urandom_range(0, 1));
      end
      nreq = (r >= TO) ? TO : r + 1;
      for (int i = a + 1; i <= a + nreq; i++) begin
        exp_sv[i]  = 4'b0001 << sel;
        exp_sa[i]  = addr;
        exp_swe[i] = we;
        exp_swd[i] = wd;
      end
      for (int i = a + 1; i < c; i++) begin
        drv_sr[i][sel]  = 1'b0;
        drv_srv[i][sel] = 1'b0;
      end
      h = a + 1 + r;
      if (r < TO) begin
        drv_sr[h][sel] = 1'b1;
        if (!we && v <= TO) begin
          drv_srv[h+v][sel] = 1'b1;
          drv_srd[h+v][sel*DW +: DW] = rd;
        end
      end
      exp_rv[c] = 1'b1;
      exp_ce[c] = err;
      exp_cd[c] = (we || err) ? '0 : rd;
      idle = c + 1;
    end
  endtask

  initial begin
    bit e;
    logic [DW-1:0] held_d;
    bit held_e;

    // model anchors, hand-derived from the latency rules
    chk("model.store_r0", done_cycle(0, 1'b1, 0, 0, e), 2);
    chk("model.load_v1", done_cycle(0, 1'b0, 0, 1, e), 3);
    chk("model.load_v0", done_cycle(0, 1'b0, 0, 0, e), 2);
    chk("model.load_r3v2", done_cycle(0, 1'b0, 3, 2, e), 7);
    chk("model.req_to", done_cycle(0, 1'b0, TO, 0, e), 5);
    chk("model.req_to_err", e, 1);
    chk("model.wait_to", done_cycle(10, 1'b0, 0, TO + 1, e), 16);

    rst_n = 1'b0; m_valid = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    s_ready = 4'b0; s_rvalid = 4'b0; s_rdata = '0;
    step(); step();
    chk("rst.m_ready", m_ready, 0);
    chk("rst.s_valid", s_valid, 0);
    chk("rst.m_rvalid", m_rvalid, 0);
    chk("rst.m_rdata", m_rdata, 0);
    chk("rst.m_err", m_err, 0);
    rst_n = 1'b1;
    #1;
    chk("rst.m_ready_rel", m_ready, 1);

    // store to target 2, ready at once
    m_valid = 1'b1; m_we = 1'b1; m_addr = 32'h2000_0010; m_wdata = 32'hA5A5_0001;
    s_ready = 4'b0100;
    step();
    m_valid = 1'b0;
    chk("t1.s_valid", s_valid, 4'b0100);
    chk("t1.s_addr", s_addr, 32'h2000_0010);
    chk("t1.s_we", s_we, 1);
    chk("t1.s_wdata", s_wdata, 32'hA5A5_0001);
    chk("t1.m_ready_busy", m_ready, 0);
    step();
    chk("t1.s_valid_drop", s_valid, 0);
    chk("t1.m_rvalid", m_rvalid, 1);
    chk("t1.m_err", m_err, 0);
    chk("t1.m_rdata", m_rdata, 0);
    s_ready = 4'b0;
    step();
    chk("t1.m_rvalid_pulse", m_rvalid, 0);
    chk("t1.m_ready", m_ready, 1);

    // load from target 1: ready on the 4th REQ cycle, rvalid two cycles later
    m_valid = 1'b1; m_we = 1'b0; m_addr = 32'h1000_0004;
    step();
    m_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2.s_valid%0d", i), s_valid, 4'b0010);
      s_ready  = (i == 3) ? 4'b1111 : 4'b1101;
      s_rvalid = 4'b1101;
      s_rdata  = {4{32'hDEAD_BEEF}};
      step();
    end
    s_ready = 4'b1101;
    chk("t2.wait_s_valid", s_valid, 0);
    step();
    chk("t2.wait_m_rvalid", m_rvalid, 0);
    s_rvalid = 4'b1111;
    s_rdata  = {32'h3333_3333, 32'h2222_2222, 32'hCAFE_F00D, 32'h0000_0000};
    step();
    chk("t2.m_rvalid", m_rvalid, 1);
    chk("t2.m_rdata", m_rdata, 32'hCAFE_F00D);
    chk("t2.m_err", m_err, 0);
    s_ready = 4'b0; s_rvalid = 4'b0;
    step();
    chk("t2.m_rdata_hold", m_rdata, 32'hCAFE_F00D);
    chk("t2.m_rvalid_pulse", m_rvalid, 0);

    // load from target 3 with ready and rvalid together
    m_valid = 1'b1; m_we = 1'b0; m_addr = 32'h3000_0000;
    step();
    m_valid = 1'b0;
    chk("t3.s_valid", s_valid, 4'b1000);
    s_ready = 4'b1000; s_rvalid = 4'b1000;
    s_rdata = {32'h1234_5678, 96'h0};
    step();
    chk("t3.m_rvalid", m_rvalid, 1);
    chk("t3.m_rdata", m_rdata, 32'h1234_5678);
    chk("t3.m_err", m_err, 0);
    s_ready = 4'b0; s_rvalid = 4'b0;
    step();

    // target 0 never answers: timeout after TO REQ cycles, late rvalid ignored
    m_valid = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0040;
    s_ready = 4'b1110;
    step();
    m_valid = 1'b0;
    for (int i = 0; i < TO; i++) begin
      chk($sformatf("t4.s_valid%0d", i), s_valid, 4'b0001);
      chk($sformatf("t4.m_rvalid%0d", i), m_rvalid, 0);
      step();
    end
    chk("t4.m_rvalid", m_rvalid, 1);
    chk("t4.m_err", m_err, 1);
    chk("t4.m_rdata", m_rdata, 0);
    s_rvalid = 4'b0001; s_rdata = {96'h0, 32'h0000_0BAD};
    step();
    chk("t4.late_m_rvalid", m_rvalid, 0);
    chk("t4.err_hold", m_err, 1);
    chk("t4.rdata_hold", m_rdata, 0);
    chk("t4.m_ready", m_ready, 1);
    step();
    chk("t4.late_m_rvalid2", m_rvalid, 0);
    s_rvalid = 4'b0; s_ready = 4'b0;

    // reset while waiting for read data
    m_valid = 1'b1; m_we = 1'b0; m_addr = 32'h2000_0000;
    s_ready = 4'b0100;
    step();
    m_valid = 1'b0;
    chk("t5.s_valid", s_valid, 4'b0100);
    step();
    s_ready = 4'b0;
    chk("t5.wait_s_valid", s_valid, 0);
    chk("t5.wait_m_ready", m_ready, 0);
    rst_n = 1'b0;
    step();
    chk("t5.m_rvalid", m_rvalid, 0);
    chk("t5.s_valid_rst", s_valid, 0);
    chk("t5.m_err_cleared", m_err, 0);
    chk("t5.m_ready_in_rst", m_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("t5.m_ready", m_ready, 1);
    s_rvalid = 4'b0100;
    step();
    chk("t5.no_completion", m_rvalid, 0);
    s_rvalid = 4'b0;

    // randomized timeline against the behavioural model
    plan();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    held_d = '0;
    held_e = 1'b0;
    for (int c = 0; c < NC; c++) begin
      m_valid  = drv_mv[c];
      m_we     = drv_we[c];
      m_addr   = drv_addr[c];
      m_wdata  = drv_wdata[c];
      s_ready  = drv_sr[c];
      s_rvalid = drv_srv[c];
      s_rdata  = drv_srd[c];
      @(negedge clk);
      chk($sformatf("rnd%0d.m_ready", c), m_ready, exp_rdy[c]);
      chk($sformatf("rnd%0d.s_valid", c), s_valid, exp_sv[c]);
      chk($sformatf("rnd%0d.m_rvalid", c), m_rvalid, exp_rv[c]);
      if (exp_rv[c]) begin
        held_d = exp_cd[c];
        held_e = exp_ce[c];
      end
      chk($sformatf("rnd%0d.m_rdata", c), m_rdata, held_d);
      chk($sformatf("rnd%0d.m_err", c), m_err, held_e);
      if (exp_sv[c] != 4'b0) begin
        chk($sformatf("rnd%0d.s_addr", c), s_addr, exp_sa[c]);
        chk($sformatf("rnd%0d.s_we", c), s_we, exp_swe[c]);
        chk($sformatf("rnd%0d.s_wdata", c), s_wdata, exp_swd[c]);
      end
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
